// File: rtl/clause_loader.sv
// Clause loader: assembles NUMBER_OF_INTEGER_VARIABLES coefficient beats per clause and broadcasts each clause with index 1..count.
// Optional sticky overflow flag for beats offered after completion is enabled by defining CLAUSE_LOADER_OVERFLOW_EN.
module clause_loader #(
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
  parameter int NUMBER_OF_INTEGER_VARIABLES   = 2,
  parameter int CLAUSE_INDEX_WIDTH            = 2
) (
  input  logic                                                           in_clk,
  input  logic                                                           in_reset,
  input  logic                                                           in_start,
  input  logic [CLAUSE_INDEX_WIDTH-1:0]                                  in_number_of_clauses,
  input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]                       in_coefficient,
  input  logic                                                           in_coefficient_valid,
  output logic                                                           out_coefficient_ready,
  output logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0] out_clause_coefficients,
  output logic [CLAUSE_INDEX_WIDTH-1:0]                                  out_clause_index,
  output logic                                                           out_busy,
  output logic                                                           out_done,
  output logic                                                           out_overflow
);

  localparam int BW     = BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int N      = NUMBER_OF_INTEGER_VARIABLES;
  localparam int CW     = CLAUSE_INDEX_WIDTH;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [CW-1:0]     clause_q, clause_d;
  logic [CW-1:0]     count_q,  count_d;
  logic [BEAT_W-1:0] beat_q,   beat_d;
  logic [BW*N-1:0]   coeff_q,  coeff_d;

  always_comb begin
    state_d  = state_q;
    clause_d = clause_q;
    count_d  = count_q;
    beat_d   = beat_q;
    coeff_d  = coeff_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_start) begin
          if (in_number_of_clauses != '0) begin
            state_d  = S_COLLECT;
            clause_d = CW'(1);
            beat_d   = '0;
            count_d  = in_number_of_clauses;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_COLLECT: begin
        if (in_coefficient_valid) begin
          // Only the addressed slice changes; the rest keeps the previous clause.
          for (int i = 0; i < N; i++) begin
            if (beat_q == BEAT_W'(i)) coeff_d[i*BW +: BW] = in_coefficient;
          end
          if (beat_q == BEAT_W'(N-1)) begin
            state_d = S_WRITE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (clause_q == count_q) begin
          state_d  = S_DONE;
        end else begin
          state_d  = S_COLLECT;
          clause_d = clause_q + CW'(1);
          beat_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q  <= S_IDLE;
      clause_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      coeff_q  <= '0;
    end else begin
      state_q  <= state_d;
      clause_q <= clause_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      coeff_q  <= coeff_d;
    end
  end

`ifdef CLAUSE_LOADER_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A new session clears the flag even if a stray beat arrives the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && in_start) begin
      overflow_d = 1'b0;
    end else if (state_q == S_DONE && in_coefficient_valid) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign out_overflow = overflow_q;
`else
  assign out_overflow = 1'b0;
`endif

  assign out_coefficient_ready   = (state_q == S_COLLECT);
  assign out_busy                = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign out_done                = (state_q == S_DONE);
  assign out_clause_index        = (state_q == S_WRITE) ? clause_q : '0;
  assign out_clause_coefficients = coeff_q;

endmodule

// File: doc/clause_loader.md
CLAUSE_LOADER -- requirements
Module: clause_loader

Interface
REQ-001 Parameter BIT_WIDTH_OF_INTEGER_VARIABLE, default 2: width of one clause coefficient.
REQ-002 Parameter NUMBER_OF_INTEGER_VARIABLES, default 2: coefficients per clause.
REQ-003 Parameter CLAUSE_INDEX_WIDTH, default 2: width of clause index and clause count.
REQ-004 in_clk  input  1  single clock; all state updates on rising edge.
REQ-005 in_reset  input  1  asynchronous, active-high reset.
REQ-006 in_start  input  1  one-cycle pulse starting a load session.
REQ-007 in_number_of_clauses  input  CLAUSE_INDEX_WIDTH  clauses in the session, sampled at in_start.
REQ-008 in_coefficient  input  BIT_WIDTH_OF_INTEGER_VARIABLE  one coefficient beat.
REQ-009 in_coefficient_valid  input  1  in_coefficient is valid.
REQ-010 out_coefficient_ready  output  1  loader accepts a beat this cycle.
REQ-011 out_clause_coefficients  output  BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES  packed clause broadcast to the clause register bank.
REQ-012 out_clause_index  output  CLAUSE_INDEX_WIDTH  target clause identifier; 0 = no write.
REQ-013 out_busy  output  1  session in progress.
REQ-014 out_done  output  1  session complete.
REQ-015 out_overflow  output  1  sticky extra-beat error (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, WRITE, DONE; all outputs registered or decoded from state only.
REQ-017 IDLE: ready=0, index=0, busy=0, done=0; in_start with count!=0 -> COLLECT, clause counter=1, beat counter=0, count latched; in_start with count=0 -> DONE.
REQ-018 COLLECT: ready=1, busy=1, index=0; beat accepted when valid&&ready, stored at slice [beat*BW +: BW] (beat 0 = least significant); last beat (beat=N-1) -> WRITE.
REQ-019 Beats not yet overwritten SHALL retain previous clause values; out_clause_coefficients SHALL change only on accepted beats.
REQ-020 WRITE: exactly one cycle, index=clause counter, ready=0, busy=1, coefficients stable.
REQ-021 From WRITE: counter==latched count -> DONE; else counter+1, beat=0 -> COLLECT.
REQ-022 DONE: done=1, busy=0, ready=0, index=0; in_start restarts exactly as from IDLE.
REQ-023 in_start SHALL be ignored in COLLECT and WRITE; in_number_of_clauses changes after start SHALL have no effect.
REQ-024 Valid low in COLLECT SHALL stall without state change; throughput is N+1 cycles per clause with valid held high.
REQ-025 Clause indices SHALL run 1..count in order, each issued exactly once per session; index never wraps (max count 2^CLAUSE_INDEX_WIDTH-1).

Reset
REQ-026 in_reset SHALL immediately force IDLE, counters 0, coefficients 0, index 0, ready/busy/done/overflow 0, including mid-session.
REQ-027 First in_start after reset release SHALL be honoured on the first clock edge.

Configuration
REQ-028 Macro CLAUSE_LOADER_OVERFLOW_EN defined: out_overflow sets when in_coefficient_valid=1 in DONE, stays 1 until reset or next in_start.
REQ-029 Macro CLAUSE_LOADER_OVERFLOW_EN undefined: out_overflow tied 0, no overflow logic; all other behaviour identical.

Verification
REQ-030 Reset, start count=2, beats 1,2 then 3,0 valid continuous -> WRITE index=1 coeff=4'b1001 at cycle 3, index=2 coeff=4'b0011 at cycle 6, done=1 at cycle 7.
REQ-031 Start count=1, valid low 3 cycles between beats -> ready stays 1, state held, single index=1 pulse after second beat.
REQ-032 Start count=0 -> done=1 next cycle, index never non-zero, ready never 1.
REQ-033 Assert in_reset after first beat of clause 2 (count=3) -> all outputs 0 asynchronously; restart count=1 completes normally.
REQ-034 With CLAUSE_LOADER_OVERFLOW_EN, valid=1 in DONE -> overflow=1 next edge, cleared by in_start; without macro overflow stays 0.
REQ-035 in_start pulsed during COLLECT with different count -> ignored, original count completes.
